// File: rtl/cprv_muldiv_pkg.sv
// Shared types and decode constants for the iterative RV64M multiply/divide sequencer.
package cprv_muldiv_pkg;

  // Encoded to match funct3 so the op can be taken straight from the instruction.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP32      = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/cprv_muldiv_iter.sv
// One radix-2 step on the 128-bit accumulator: shift-add (multiply) or restoring subtract (divide).
module cprv_muldiv_iter (
  input  logic        is_div,
  input  logic [63:0] acc_hi,
  input  logic [63:0] acc_lo,
  input  logic [63:0] b,
  output logic [63:0] nxt_hi,
  output logic [63:0] nxt_lo
);
  logic [64:0] sum, rem, diff;

  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : 65'd0);
    // Partial remainder stays below the divisor, so 65 bits cannot wrap on a true non-negative diff.
    rem  = {acc_hi, acc_lo[63]};
    diff = rem - {1'b0, b};
    if (is_div) begin
      if (!diff[64]) begin
        nxt_hi = diff[63:0];
        nxt_lo = {acc_lo[62:0], 1'b1};
      end else begin
        nxt_hi = rem[63:0];
        nxt_lo = {acc_lo[62:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[64:1];
      nxt_lo = {sum[0], acc_lo[63:1]};
    end
  end

endmodule

// File: rtl/cprv_muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer: accepts one op, iterates on magnitudes, sign-corrects in FIN.
module cprv_muldiv_seq
  import cprv_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter bit EARLY_OUT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic                  kill_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            rd_addr_o,
  output logic                  busy_o
);
  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN32X = 64'hFFFF_FFFF_8000_0000;

  md_state_e   state, state_nxt;
  md_op_e      op_in, op_r;
  logic        w_in, w_r, neg_r, early_r;
  logic [6:0]  cnt;
  logic [63:0] acc_hi, acc_lo, b_r, nxt_hi, nxt_lo;

  logic        legal, accept, a_sgn, b_sgn, a_neg, b_neg, is_div, is_rem;
  logic        b_zero, ovf, early, neg_in;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, early_res, init_lo, fin_res, sel64;
  logic [31:0] sel32;
  logic [127:0] prod;

  assign op_in   = md_op_e'(funct3_i);
  assign w_in    = (opcode_i == OPC_OP32);
  assign legal   = (funct7_i == FUNCT7_MULDIV) &&
                   ((opcode_i == OPC_OP) || (w_in && (op_in == MUL || funct3_i[2])));
  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign valid_o = (state == DONE);
  assign accept  = valid_i && ready_o && legal && !kill_i;

  assign is_div = funct3_i[2];
  assign is_rem = funct3_i[2] & funct3_i[1];
  assign a_sgn  = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
  assign b_sgn  = (op_in == MULH) || (op_in == DIV) || (op_in == REM);

  assign a_ext = !w_in ? rs1_data_i :
                 a_sgn ? {{32{rs1_data_i[31]}}, rs1_data_i[31:0]} : {32'd0, rs1_data_i[31:0]};
  assign b_ext = !w_in ? rs2_data_i :
                 b_sgn ? {{32{rs2_data_i[31]}}, rs2_data_i[31:0]} : {32'd0, rs2_data_i[31:0]};
  assign a_neg = a_sgn & a_ext[63];
  assign b_neg = b_sgn & b_ext[63];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  assign b_zero = (b_ext == '0);
  assign ovf    = is_div && b_sgn && (b_ext == '1) && (a_ext == (w_in ? MIN32X : MIN64));
  assign early  = EARLY_OUT && is_div && (b_zero || ovf);
  assign neg_in = is_rem ? a_neg : ((a_neg ^ b_neg) && !b_zero);

  always_comb begin
    if (b_zero)
      early_res = is_rem ? (w_in ? {{32{rs1_data_i[31]}}, rs1_data_i[31:0]} : rs1_data_i) : '1;
    else
      early_res = is_rem ? '0 : a_ext;
    // W divides feed the dividend MSB-first from bit 63, so park it in the upper half.
    if (early)
      init_lo = early_res;
    else if (is_div && w_in)
      init_lo = {a_mag[31:0], 32'd0};
    else
      init_lo = a_mag;
  end

  cprv_muldiv_iter u_iter (
    .is_div (op_r[2]),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .b      (b_r),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // A 32-step multiply leaves the product in acc[95:32]; a 32-step divide leaves q/r in the low words.
  always_comb begin
    prod  = neg_r ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    sel64 = (op_r == REM || op_r == REMU) ? acc_hi : acc_lo;
    sel32 = !op_r[2] ? acc_lo[63:32] : sel64[31:0];
    if (neg_r) begin
      sel64 = -sel64;
      sel32 = -sel32;
    end
    if (early_r)
      fin_res = acc_lo;
    else if (w_r)
      fin_res = {{32{sel32[31]}}, sel32};
    else if (!op_r[2])
      fin_res = (op_r == MUL) ? prod[63:0] : prod[127:64];
    else
      fin_res = sel64;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Early-outs still pass through FIN so every op registers its result at the same point.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early ? FIN : CALC;
      CALC:    if (cnt == 7'd1) state_nxt = FIN;
      FIN:     state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= MUL;
      w_r       <= 1'b0;
      neg_r     <= 1'b0;
      early_r   <= 1'b0;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      b_r       <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (accept) begin
      op_r      <= op_in;
      w_r       <= w_in;
      neg_r     <= neg_in;
      early_r   <= early;
      cnt       <= w_in ? 7'd32 : 7'd64;
      acc_hi    <= '0;
      acc_lo    <= init_lo;
      b_r       <= b_mag;
      rd_addr_o <= rd_addr_i;
    end else if (state == CALC) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt - 7'd1;
    end else if (state == FIN) begin
      result_o <= fin_res;
    end
  end

endmodule

// File: tb/tb_cprv_muldiv_seq.sv
// Bench for cprv_muldiv_seq: directed vectors, an arithmetic reference model and a per-cycle scoreboard monitor.
module tb_cprv_muldiv_seq;
  import cprv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b1;
  logic        ready_o, valid_o, busy_o;
  logic [63:0] rs1_data_i = '0, rs2_data_i = '0, result_o;
  logic [4:0]  rd_addr_i = '0, rd_addr_o;
  logic [6:0]  opcode_i = OPC_OP, funct7_i = FUNCT7_MULDIV;
  logic [2:0]  funct3_i = '0;

  int   checks = 0, errors = 0, cyc = 0;
  logic in_flight = 1'b0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
    int          acc_cyc;
    bit          seen;
  } exp_t;
  exp_t sb[$];

  cprv_muldiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .funct7_i   (funct7_i),
    .kill_i     (kill_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: RV64M results straight from the ISA rules using wide arithmetic.
  function automatic logic [63:0] model(input logic w, input md_op_e op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    logic signed [63:0]  sa, sbv, sq;
    logic signed [31:0]  a32, b32, q32;
    logic [31:0]         t;
    logic [63:0]         r;
    sa = a; sbv = b; a32 = a[31:0]; b32 = b[31:0];
    p = '0; sq = '0; q32 = '0; t = '0; r = '0;
    if (!w) begin
      case (op)
        MUL:    r = a * b;
        MULH:   begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
        MULHSU: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = p[127:64]; end
        MULHU:  begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
        DIV, REM: begin
          if (b == 64'd0) r = (op == DIV) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
          else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = (op == DIV) ? a : 64'd0;
          else begin
            sq = (op == DIV) ? sa / sbv : sa % sbv;
            r = sq;
          end
        end
        default: begin
          if (b == 64'd0) r = (op == DIVU) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
          else r = (op == DIVU) ? a / b : a % b;
        end
      endcase
    end else begin
      case (op)
        MUL: t = a[31:0] * b[31:0];
        DIV, REM: begin
          if (b[31:0] == 32'd0) t = (op == DIV) ? 32'hFFFF_FFFF : a[31:0];
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) t = (op == DIV) ? a[31:0] : 32'd0;
          else begin
            q32 = (op == DIV) ? a32 / b32 : a32 % b32;
            t = q32;
          end
        end
        default: begin
          if (b[31:0] == 32'd0) t = (op == DIVU) ? 32'hFFFF_FFFF : a[31:0];
          else t = (op == DIVU) ? a[31:0] / b[31:0] : a[31:0] % b[31:0];
        end
      endcase
      r = {{32{t[31]}}, t};
    end
    return r;
  endfunction

  // Cycles from the accept edge to the first cycle valid_o is high.
  function automatic int exp_lat(input logic w, input md_op_e op, input logic [63:0] a, input logic [63:0] b);
    logic dz, ov, dv;
    dv = (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    dz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov = (op == DIV || op == REM) &&
         (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
            : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (dv && (dz || ov)) return 2;
    return w ? 34 : 66;
  endfunction

  // Scoreboard: ready/busy track outstanding work, results and rd held while valid_o.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_o", 64'(ready_o), 64'(!in_flight));
      check("busy_o", 64'(busy_o), 64'(in_flight));
      if (valid_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_valid: valid_o=1 with nothing outstanding");
        end else begin
          check("result_o", result_o, sb[0].res);
          check("rd_addr_o", 64'(rd_addr_o), 64'(sb[0].rd));
          if (!sb[0].seen) begin
            sb[0].seen = 1'b1;
            check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
          end
          if (ready_i) begin
            void'(sb.pop_front());
            in_flight = 1'b0;
          end
        end
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic issue(input logic w, input md_op_e op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] res, input int lat);
    exp_t e;
    opcode_i = w ? OPC_OP32 : OPC_OP; funct3_i = op; funct7_i = FUNCT7_MULDIV;
    rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; valid_i = 1'b1;
    e.res = res; e.rd = rd; e.lat = lat; e.acc_cyc = cyc; e.seen = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    sb.push_back(e);
    in_flight = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (in_flight && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_flight) begin
      checks++; errors++;
      $display("FAIL timeout: op still outstanding after %0d cycles", n);
      sb.delete();
      in_flight = 1'b0;
    end
  endtask

  task automatic vec(input logic w, input md_op_e op, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] rd, input logic [63:0] res, input int lat);
    check("model_pin", model(w, op, a, b), res);
    issue(w, op, a, b, rd, res, lat);
    wait_done();
  endtask

  task automatic mvec(input logic w, input md_op_e op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    issue(w, op, a, b, rd, model(w, op, a, b), exp_lat(w, op, a, b));
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, 64'(valid_o), 64'd0);
    check({tag, "_ready_o"}, 64'(ready_o), 64'd1);
    check({tag, "_busy_o"}, 64'(busy_o), 64'd0);
    check({tag, "_result_o"}, result_o, 64'd0);
    check({tag, "_rd_addr_o"}, 64'(rd_addr_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    vec(1'b0, MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    vec(1'b0, MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    vec(1'b0, MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    vec(1'b0, DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    vec(1'b0, REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    vec(1'b0, DIVU,   64'd100, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    vec(1'b0, REMU,   64'd100, 64'd0, 5'd7, 64'd100, 2);
    vec(1'b0, DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'h8000_0000_0000_0000, 2);
    vec(1'b0, REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'd0, 2);
    vec(1'b1, DIV,    64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'hFFFF_FFFF_8000_0000, 2);

    mvec(1'b0, MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd12);
    mvec(1'b0, MULH,   64'hFFFF_FFFF_FFFF_FFFB, 64'h0123_4567_89AB_CDEF, 5'd13);
    mvec(1'b0, MULHSU, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14);
    mvec(1'b0, DIVU,   64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 5'd15);
    mvec(1'b0, REM,    64'd17, 64'hFFFF_FFFF_FFFF_FFFB, 5'd16);
    mvec(1'b0, DIV,    64'd5, 64'd0, 5'd17);
    mvec(1'b1, REM,    64'h0000_0000_FFFF_FFF9, 64'd2, 5'd18);
    mvec(1'b1, DIVU,   64'h1234_5678_FFFF_FFFF, 64'd2, 5'd19);
    mvec(1'b1, REMU,   64'h0000_0000_8000_0005, 64'h10, 5'd20);
    mvec(1'b1, REMU,   64'h0000_0000_8000_0000, 64'd0, 5'd21);
    mvec(1'b1, MUL,    64'hDEAD_BEEF_1234_5678, 64'hCAFE_F00D_8765_4321, 5'd22);

    // MULW with the downstream stalled: result and rd must hold while valid_o waits.
    ready_i = 1'b0;
    check("model_pin", model(1'b1, MUL, 64'h0000_0001_7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    issue(1'b1, MUL, 64'h0000_0001_7FFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    n = 0;
    while (!valid_o && n < 100) begin @(posedge clk); #1; n++; end
    check("mulw_valid_seen", 64'(valid_o), 64'd1);
    repeat (5) @(posedge clk);
    #1 ready_i = 1'b1;
    wait_done();

    // Ops that must be ignored: bad funct7, MULH on OP-32, non-M opcode, and kill beating accept.
    opcode_i = OPC_OP; funct7_i = 7'd0; funct3_i = 3'd0; valid_i = 1'b1;
    @(posedge clk); #1;
    opcode_i = OPC_OP32; funct7_i = FUNCT7_MULDIV; funct3_i = 3'd1;
    @(posedge clk); #1;
    opcode_i = 7'b0010011; funct3_i = 3'd0;
    @(posedge clk); #1;
    opcode_i = OPC_OP; kill_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Kill during the tenth CALC cycle.
    issue(1'b0, MUL, 64'd123, 64'd456, 5'd23, 64'd0, 66);
    repeat (9) @(posedge clk);
    #1 kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    sb.delete();
    in_flight = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    vec(1'b0, DIVU, 64'd9, 64'd3, 5'd24, 64'd3, 66);

    // Reset mid-divide returns every output to its reset value.
    issue(1'b0, DIV, 64'd1000, 64'd7, 5'd25, 64'd0, 66);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    in_flight = 1'b0;
    check_reset_outputs("midop_reset");
    repeat (80) @(posedge clk);
    #1;
    vec(1'b0, DIVU, 64'd9, 64'd3, 5'd26, 64'd3, 66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
